// File: rtl/fib_ctrl_pkg.sv
// Shared types and constants for the on-demand Fibonacci controller.
// The sequence is seeded with F(0) = F(1) = 1.
package fib_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned FIB_W     = 32;
    localparam int unsigned FIB_IDX_W = 6;
    localparam logic [63:0] FIB_SEED  = 64'd1;

    // Width of a requester id; a single requester still gets one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/fib_ctrl_rr_arb.sv
// N_REQ-wide round-robin arbiter with a one-hot grant.
// The priority pointer is kept as a mask of the requesters that rank above the wrap point.
module rr_arb
    import fib_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0] mask_q;
    logic [N_REQ-1:0] mask_d;
    logic [N_REQ-1:0] masked_s;
    logic [N_REQ-1:0] src_s;
    logic [N_REQ-1:0] pick_s;

    // Prefer requests at or above the pointer; wrap to the full vector when none remain.
    always_comb begin
        masked_s = req & mask_q;
        if (|masked_s) begin
            src_s = masked_s;
        end else begin
            src_s = req;
        end
        pick_s = src_s & (~src_s + N_REQ'(1));
        if (enable) begin
            grant = pick_s;
        end else begin
            grant = '0;
        end
    end

    // After a grant to requester i, only requesters above i keep the upper-priority mask.
    always_comb begin
        if (advance) begin
            mask_d = ~((grant << 1'b1) - N_REQ'(1));
        end else begin
            mask_d = mask_q;
        end
    end

    // Pointer register; an all-ones mask gives requester 0 the top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/fib_ctrl.sv
// Shared Fibonacci engine: arbitrates requesters, iterates the two-register datapath
// index-many times and returns F(n) mod 2^W with a sticky overflow flag.
module fib_ctrl
    import fib_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = FIB_IDX_W,
    parameter int unsigned W     = FIB_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*IDX_W-1:0]       req_n,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [id_width(N_REQ)-1:0]   rsp_id,
    output logic [W-1:0]                 rsp_data,
    output logic                         rsp_ovf,
    output logic                         busy
);

    localparam int unsigned      ID_W    = id_width(N_REQ);
    localparam logic [W-1:0]     SEED    = W'(FIB_SEED);
    localparam logic [IDX_W-1:0] CNT_TWO = IDX_W'(2);

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic [W:0]       sum_s;
    logic             accept_s;
    logic [ID_W-1:0]  id_sel_s;
    logic [IDX_W-1:0] n_sel_s;

    rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .enable  (state_q == IDLE),
        .advance (accept_s),
        .grant   (req_ready)
    );

    assign accept_s = |(req_valid & req_ready);
    assign sum_s    = {1'b0, a_q} + {1'b0, b_q};

    // Encode the one-hot grant into an id and select that requester's index.
    always_comb begin
        id_sel_s = '0;
        n_sel_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                id_sel_s = ID_W'(i);
                n_sel_s  = req_n[i*IDX_W +: IDX_W];
            end else begin
                id_sel_s = id_sel_s;
                n_sel_s  = n_sel_s;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = CALC;
                    a_d     = SEED;
                    b_d     = SEED;
                    cnt_d   = n_sel_s;
                    id_d    = id_sel_s;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q < CNT_TWO) begin
                    state_d = RESP;
                end else begin
                    a_d   = b_q;
                    b_d   = sum_s[W-1:0];
                    cnt_d = cnt_q - IDX_W'(1);
                    ovf_d = ovf_q | sum_s[W];
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            id_q    <= id_d;
        end
    end

    // Response fields come straight from flops, which stay frozen while in RESP.
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = b_q;
    assign rsp_ovf   = ovf_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fib_ctrl.sv
// Self-checking bench for fib_ctrl: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model.
module tb_fib_ctrl;

    localparam int N = 2;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*IW-1:0] req_n = '0;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [0:0]    rsp_id;
    logic [31:0]   rsp_data;
    logic          rsp_ovf;
    logic          busy;

    int checks = 0;
    int failures = 0;

    fib_ctrl #(.N_REQ(N), .IDX_W(IW), .W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // True (unbounded) Fibonacci value with F(0)=F(1)=1.
    function automatic longint unsigned fib(input int n);
        longint unsigned x, y, t;
        x = 64'd1;
        y = 64'd1;
        for (int k = 2; k <= n; k++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return y;
    endfunction

    // Round-robin choice: first valid requester starting from the priority position.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Transaction-level model state.
    bit              model_on = 1'b0;
    bit              m_busy = 1'b0;
    bit              m_valid = 1'b0;
    int              m_wait = 0;
    int              m_id = 0;
    longint unsigned m_val = 0;
    int              m_ptr = 0;
    int              grant_log[$];
    int              rsp_id_log[$];

    // Compare DUT against the model, log handshakes, then advance the model over the next edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int pick;
        pick = m_busy ? -1 : rr_pick(req_valid, m_ptr);
        exp_ready = (pick >= 0) ? N'(1 << pick) : '0;
        if (model_on) begin
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, m_valid);
            if (m_valid) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_data", rsp_data, m_val & 64'hFFFF_FFFF);
                chk("rsp_ovf", rsp_ovf, (m_val > 64'hFFFF_FFFF) ? 1 : 0);
            end
            if (|(req_ready & req_valid) && !rst) grant_log.push_back(pick);
            if (rsp_valid && rsp_ready && !rst) rsp_id_log.push_back(int'(rsp_id));
        end
        if (rst) begin
            model_on = 1'b1;
            m_busy = 1'b0;
            m_valid = 1'b0;
            m_ptr = 0;
        end else if (model_on) begin
            if (!m_busy) begin
                if (pick >= 0) begin
                    m_busy = 1'b1;
                    m_id = pick;
                    m_val = fib(int'(req_n[pick*IW +: IW]));
                    m_wait = (req_n[pick*IW +: IW] > 1) ? int'(req_n[pick*IW +: IW]) : 1;
                    m_ptr = (pick + 1) % N;
                end
            end else if (!m_valid) begin
                m_wait--;
                if (m_wait == 0) m_valid = 1'b1;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
                m_busy = 1'b0;
            end
        end
    end

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Wait (bounded) until requester id is accepted; leaves the caller in the accept cycle's negedge.
    task automatic wait_accept(input int id, output bit got);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id] && req_valid[id]) got = 1'b1;
        end
        chk("accept_timeout", got, 1);
    endtask

    task automatic do_req(input int id, input int n, input longint unsigned ed, input int eo, input int elat);
        bit got;
        int lat;
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        req_n[id*IW +: IW] = IW'(n);
        wait_accept(id, got);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        for (lat = 1; lat < 200; lat++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("latency", lat, elat);
        chk("dir_rsp_data", rsp_data, ed);
        chk("dir_rsp_ovf", rsp_ovf, eo);
        chk("dir_rsp_id", rsp_id, id);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300 && busy; c++) @(negedge clk);
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        bit got;
        int cnt;

        chk("model_fib10", fib(10), 89);
        chk("model_fib46", fib(46), 64'd2971215073);
        chk("model_fib47_lo", fib(47) & 64'hFFFF_FFFF, 64'd512559680);

        // Single requests, including the overflow boundary.
        reset_dut();
        do_req(0, 0, 1, 0, 2);
        do_req(0, 1, 1, 0, 2);
        do_req(0, 10, 89, 0, 11);
        do_req(0, 46, 64'd2971215073, 0, 47);
        do_req(0, 47, 64'd512559680, 1, 48);
        do_req(0, 3, 3, 0, 4);
        wait_idle();

        // Contention: both requesters held high must alternate.
        reset_dut();
        grant_log.delete();
        rsp_id_log.delete();
        req_n = {6'd2, 6'd2};
        req_valid = 2'b11;
        for (int c = 0; c < 100 && rsp_id_log.size() < 4; c++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
        chk("cont_rsp_count", (rsp_id_log.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4 && i < rsp_id_log.size(); i++) begin
            chk("cont_grant_order", grant_log[i], i % 2);
            chk("cont_rsp_order", rsp_id_log[i], i % 2);
        end

        // Backpressure: response held stable, requester 1 waits, then is granted.
        reset_dut();
        rsp_ready = 1'b0;
        req_n = {6'd1, 6'd4};
        req_valid = 2'b11;
        wait_accept(0, got);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        for (int c = 0; c < 50 && !rsp_valid; c++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 5);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready_low", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_grant1", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Reset in the middle of a long computation.
        reset_dut();
        req_n[IW-1:0] = 6'd30;
        req_valid[0] = 1'b1;
        wait_accept(0, got);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rsp_valid, 0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("midrst_no_rsp", cnt, 0);
        do_req(1, 2, 2, 0, 3);
        wait_idle();

        // Withdrawn request: a one-cycle pulse while busy is never served.
        grant_log.delete();
        rsp_id_log.delete();
        @(posedge clk); #1;
        req_n[IW-1:0] = 6'd8;
        req_valid[0] = 1'b1;
        wait_accept(0, got);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        wait_idle();
        cnt = 0;
        foreach (grant_log[i]) if (grant_log[i] == 1) cnt++;
        foreach (rsp_id_log[i]) if (rsp_id_log[i] == 1) cnt++;
        chk("withdraw_never_served", cnt, 0);
        chk("withdraw_rsp_count", rsp_id_log.size(), 1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            req_valid = N'($urandom);
            req_n = (N*IW)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
